load_store_unit: RTL and testbench

- Memory-stage block directly downstream of the ALU.
- Consumes ALUResult as the effective address and the rs2 value as store data.
- Runs a handshaked request/response transaction to data memory, with byte-lane alignment and load sign/zero extension.
- Stalls the pipeline while an access is outstanding; flags misaligned or illegal accesses instead of issuing them.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 81 ++++++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM encodings, RISC-V width/sign
// field values and the byte-enable width.
package lsu_pkg;

  localparam int LSU_BE_WIDTH = 4;

  // FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Funct3 width/sign field
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: store byte-lane
// replication and byte enables, access legality/alignment checks, and load
// lane selection with sign/zero extension. Fixed at a 32-bit datapath.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        illegal,
  output logic        misaligned,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_off,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Store side: replicate the narrow datum into every lane and enable only the addressed ones
  always_comb begin
    be         = 4'b0000;
    wdata_lane = store_data;
    case (funct3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{store_data[15:0]}};
      end
      F3_W: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Legality first; alignment only matters for an otherwise legal access
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (mem_read && mem_write) begin
      illegal = 1'b1;
    end else if (mem_write) begin
      illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    end else if (mem_read) begin
      illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    if (!illegal) begin
      case (funct3)
        F3_H, F3_HU: misaligned = addr_lo[0];
        F3_W:        misaligned = |addr_lo;
        default:     misaligned = 1'b0;
      endcase
    end
  end

  // Load side: pick the addressed byte/half from the returned word and extend it
  always_comb begin
    case (load_off)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase
    lane_half = load_off[1] ? rdata[31:16] : rdata[15:0];
    case (load_funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_data = {24'b0, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data = {16'b0, lane_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Takes the ALU result as the effective address,
// runs one request/response transaction to data memory and stalls the
// pipeline while it is outstanding.
//
// Handshake: dmem_req is held high with dmem_we/addr/be/wdata stable until
// the cycle dmem_ready is sampled high; that cycle is the transfer. Read data
// is taken in the single cycle dmem_rvalid is high while waiting for it;
// dmem_rvalid at any other time is ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = LSU_BE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidM,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  Flush,
  output logic                  Stall,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Done,
  output logic                  Misaligned,
  output logic                  Illegal,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [BE_WIDTH-1:0]   dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [1:0]            dbg_state
);

  logic [1:0]            state_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            f3_q;
  logic                  we_q;
  logic [1:0]            off_q;
  logic                  drop_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  illegal_q;
  logic                  misaligned_q;

  logic                  chk_illegal;
  logic                  chk_misaligned;
  logic [BE_WIDTH-1:0]   lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  access;
  logic                  accept;

  lsu_align u_align (
    .mem_read    (MemRead),
    .mem_write   (MemWrite),
    .funct3      (Funct3),
    .addr_lo     (ALUResult[1:0]),
    .store_data  (WriteData),
    .be          (lane_be),
    .wdata_lane  (lane_wdata),
    .illegal     (chk_illegal),
    .misaligned  (chk_misaligned),
    .load_funct3 (f3_q),
    .load_off    (off_q),
    .rdata       (dmem_rdata),
    .load_data   (load_data)
  );

  assign access = ValidM && (MemRead || MemWrite) && !Flush;
  assign accept = (state_q == S_IDLE) && access && !chk_illegal && !chk_misaligned;

  // FSM and transaction registers; a killed load keeps waiting for its data so it can be discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      off_q        <= '0;
      drop_q       <= 1'b0;
      rdata_q      <= '0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (access) begin
            if (chk_illegal) begin
              illegal_q <= 1'b1;
            end else if (chk_misaligned) begin
              misaligned_q <= 1'b1;
            end else begin
              addr_q  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
              be_q    <= lane_be;
              wdata_q <= lane_wdata;
              f3_q    <= Funct3;
              we_q    <= MemWrite;
              off_q   <= ALUResult[1:0];
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (Flush) begin
            state_q <= S_IDLE;
          end else if (dmem_ready) begin
            state_q <= we_q ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              rdata_q <= load_data;
              state_q <= S_DONE;
            end
          end else if (Flush) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Stall      = accept || (state_q == S_REQ) || (state_q == S_WAIT);
  assign Done       = (state_q == S_DONE);
  assign ReadData   = rdata_q;
  assign Misaligned = misaligned_q;
  assign Illegal    = illegal_q;
  assign dmem_req   = (state_q == S_REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed accesses with hand-computed results.
// Drivers push the expected response (Done/Misaligned/Illegal plus load data)
// into a queue; a monitor pops and compares whenever the DUT pulses one.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_MIS  = 2'd2;
  localparam logic [1:0] K_ILL  = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM, MemRead, MemWrite, Flush;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic        Stall, Done, Misaligned, Illegal;
  logic [31:0] ReadData;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // {check_data, kind[1:0], data[31:0]}
  logic [34:0] exp_q[$];
  logic [34:0] mon_e;
  logic [1:0]  mon_kind;

  load_store_unit dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData), .Flush(Flush),
    .Stall(Stall), .ReadData(ReadData), .Done(Done), .Misaligned(Misaligned),
    .Illegal(Illegal), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dbg_state(dbg_state)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && (Done || Misaligned || Illegal)) begin
      mon_kind = Done ? K_DONE : (Misaligned ? K_MIS : K_ILL);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_response: got kind %0d expected none", mon_kind);
      end else begin
        mon_e = exp_q.pop_front();
        check32("resp_kind", {30'b0, mon_kind}, {30'b0, mon_e[33:32]});
        if (mon_e[34]) check32("resp_data", ReadData, mon_e[31:0]);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ValidM = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
    ALUResult = 32'h0; WriteData = 32'h0; Flush = 1'b0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h5A5A5A5A;
  endtask

  task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    ValidM = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = a; WriteData = wd;
  endtask

  // Legal access; starts and ends just after a rising edge
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int rdy_dly, input int rv_dly, input logic [31:0] rdata,
                           input logic flush_at_rv,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_read);
    if (wr) exp_q.push_back({1'b0, K_DONE, 32'h0});
    else    exp_q.push_back({1'b1, K_DONE, exp_read});
    present(rd, wr, f3, a, wd);
    @(negedge clk);
    check1({tag, "_accept_stall"}, Stall, 1'b1);
    check1({tag, "_accept_noreq"}, dmem_req, 1'b0);
    next_cycle();
    idle_inputs();
    for (int i = 0; i <= rdy_dly; i++) begin
      dmem_ready = (i == rdy_dly);
      @(negedge clk);
      check1({tag, "_req"}, dmem_req, 1'b1);
      check1({tag, "_req_stall"}, Stall, 1'b1);
      check1({tag, "_req_we"}, dmem_we, wr);
      check32({tag, "_req_addr"}, dmem_addr, exp_addr);
      if (wr) begin
        check32({tag, "_req_be"}, {28'b0, dmem_be}, {28'b0, exp_be});
        check32({tag, "_req_wdata"}, dmem_wdata, exp_wdata);
      end
      check1({tag, "_req_nodone"}, Done, 1'b0);
      next_cycle();
    end
    dmem_ready = 1'b0;
    if (rd) begin
      for (int i = 0; i <= rv_dly; i++) begin
        dmem_rvalid = (i == rv_dly);
        dmem_rdata  = (i == rv_dly) ? rdata : 32'h5A5A5A5A;
        Flush       = (i == rv_dly) && flush_at_rv;
        @(negedge clk);
        check1({tag, "_wait_stall"}, Stall, 1'b1);
        check1({tag, "_wait_noreq"}, dmem_req, 1'b0);
        check1({tag, "_wait_nodone"}, Done, 1'b0);
        next_cycle();
      end
      idle_inputs();
    end
    @(negedge clk);
    check1({tag, "_done_pulse"}, Done, 1'b1);
    check1({tag, "_done_stall"}, Stall, 1'b0);
    next_cycle();
  endtask

  // Access that must be refused with a one-cycle Illegal or Misaligned pulse
  task automatic do_reject(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [1:0] kind);
    exp_q.push_back({1'b0, kind, 32'h0});
    present(rd, wr, f3, a, 32'h13572468);
    @(negedge clk);
    check1({tag, "_stall"}, Stall, 1'b0);
    check1({tag, "_noreq"}, dmem_req, 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check1({tag, "_pulse_ill"}, Illegal, kind == K_ILL);
    check1({tag, "_pulse_mis"}, Misaligned, kind == K_MIS);
    check1({tag, "_noreq2"}, dmem_req, 1'b0);
    check32({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    next_cycle();
    @(negedge clk);
    check1({tag, "_pulse_end"}, Illegal | Misaligned, 1'b0);
    next_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_stall"}, Stall, 1'b0);
    check1({tag, "_done"}, Done, 1'b0);
    check1({tag, "_mis"}, Misaligned, 1'b0);
    check1({tag, "_ill"}, Illegal, 1'b0);
    check1({tag, "_req"}, dmem_req, 1'b0);
    check1({tag, "_we"}, dmem_we, 1'b0);
    check32({tag, "_addr"}, dmem_addr, 32'h0);
    check32({tag, "_be"}, {28'b0, dmem_be}, 32'h0);
    check32({tag, "_wdata"}, dmem_wdata, 32'h0);
    check32({tag, "_rdata"}, ReadData, 32'h0);
    check32({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Stores
    do_access("sw",   1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    do_access("sh",   1'b0, 1'b1, F3_H, 32'h102, 32'h0000ABCD, 0, 0, 32'h0, 1'b0, 32'h100, 4'b1100, 32'hABCDABCD, 32'h0);
    do_access("sh0",  1'b0, 1'b1, F3_H, 32'h100, 32'hFFFF1234, 0, 0, 32'h0, 1'b0, 32'h100, 4'b0011, 32'h12341234, 32'h0);
    do_access("sb1",  1'b0, 1'b1, F3_B, 32'h101, 32'h12345678, 0, 0, 32'h0, 1'b0, 32'h100, 4'b0010, 32'h78787878, 32'h0);
    do_access("sb3",  1'b0, 1'b1, F3_B, 32'h103, 32'h000000A5, 1, 0, 32'h0, 1'b0, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0);

    // Loads
    do_access("lb",   1'b1, 1'b0, F3_B,  32'h203, 32'h0, 0, 0, 32'h80FF7F01, 1'b0, 32'h200, 4'b0, 32'h0, 32'hFFFFFF80);
    do_access("lbu",  1'b1, 1'b0, F3_BU, 32'h203, 32'h0, 0, 0, 32'h80FF7F01, 1'b0, 32'h200, 4'b0, 32'h0, 32'h00000080);
    do_access("lh",   1'b1, 1'b0, F3_H,  32'h202, 32'h0, 0, 0, 32'h80FF7F01, 1'b0, 32'h200, 4'b0, 32'h0, 32'hFFFF80FF);
    do_access("lb1",  1'b1, 1'b0, F3_B,  32'h201, 32'h0, 0, 0, 32'h80FF7F01, 1'b0, 32'h200, 4'b0, 32'h0, 32'h0000007F);
    do_access("lw",   1'b1, 1'b0, F3_W,  32'h200, 32'h0, 0, 0, 32'h80FF7F01, 1'b0, 32'h200, 4'b0, 32'h0, 32'h80FF7F01);
    do_access("lh0",  1'b1, 1'b0, F3_H,  32'h300, 32'h0, 0, 0, 32'h1234F00D, 1'b0, 32'h300, 4'b0, 32'h0, 32'hFFFFF00D);
    do_access("lhu0", 1'b1, 1'b0, F3_HU, 32'h300, 32'h0, 0, 0, 32'h1234F00D, 1'b0, 32'h300, 4'b0, 32'h0, 32'h0000F00D);
    do_access("slow", 1'b1, 1'b0, F3_W,  32'h500, 32'h0, 3, 2, 32'hCAFEF00D, 1'b0, 32'h500, 4'b0, 32'h0, 32'hCAFEF00D);
    // rvalid in the same cycle Flush rises is still accepted
    do_access("flrv", 1'b1, 1'b0, F3_HU, 32'h202, 32'h0, 0, 1, 32'h80FF7F01, 1'b1, 32'h200, 4'b0, 32'h0, 32'h000080FF);

    // Refused accesses
    do_reject("mis_lw",  1'b1, 1'b0, F3_W,   32'h102, K_MIS);
    do_reject("mis_lh",  1'b1, 1'b0, F3_H,   32'h201, K_MIS);
    do_reject("mis_lhu", 1'b1, 1'b0, F3_HU,  32'h203, K_MIS);
    do_reject("mis_sw",  1'b0, 1'b1, F3_W,   32'h101, K_MIS);
    do_reject("ill_f3",  1'b1, 1'b0, 3'b011, 32'h100, K_ILL);
    do_reject("ill_rw",  1'b1, 1'b1, F3_W,   32'h100, K_ILL);
    do_reject("ill_sbu", 1'b0, 1'b1, F3_BU,  32'h100, K_ILL);
    do_reject("ill_pri", 1'b1, 1'b0, 3'b011, 32'h001, K_ILL);
    do_reject("ill_shu", 1'b0, 1'b1, F3_HU,  32'h103, K_ILL);

    // Flush alongside a request in IDLE: nothing accepted
    present(1'b1, 1'b0, F3_W, 32'h600, 32'h0);
    Flush = 1'b1;
    @(negedge clk);
    check1("idle_flush_stall", Stall, 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check32("idle_flush_state", 32'(dbg_state), 32'(S_IDLE));
    check1("idle_flush_noreq", dmem_req, 1'b0);
    next_cycle();

    // Flush while the request is pending: no Done, back to IDLE
    present(1'b1, 1'b0, F3_W, 32'h700, 32'h0);
    next_cycle();
    idle_inputs();
    Flush = 1'b1;
    @(negedge clk);
    check1("req_flush_req", dmem_req, 1'b1);
    next_cycle();
    Flush = 1'b0;
    @(negedge clk);
    check32("req_flush_state", 32'(dbg_state), 32'(S_IDLE));
    check1("req_flush_noreq", dmem_req, 1'b0);
    check1("req_flush_stall", Stall, 1'b0);
    next_cycle();

    // Flush while waiting for data: returned data is dropped, no Done
    present(1'b1, 1'b0, F3_W, 32'h300, 32'h0);
    next_cycle();
    idle_inputs();
    dmem_ready = 1'b1;
    @(negedge clk);
    check1("wait_flush_req", dmem_req, 1'b1);
    next_cycle();
    dmem_ready = 1'b0;
    Flush = 1'b1;
    @(negedge clk);
    check32("wait_flush_in_wait", 32'(dbg_state), 32'(S_WAIT));
    check1("wait_flush_stall", Stall, 1'b1);
    next_cycle();
    Flush = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h11111111;
    @(negedge clk);
    check1("wait_flush_still_stall", Stall, 1'b1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check1("wait_flush_nodone", Done, 1'b0);
    check32("wait_flush_state", 32'(dbg_state), 32'(S_IDLE));
    check32("wait_flush_rdata_kept", ReadData, 32'h000080FF);
    next_cycle();

    // rvalid while idle is ignored
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h22222222;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check1("idle_rvalid_nodone", Done, 1'b0);
    check32("idle_rvalid_state", 32'(dbg_state), 32'(S_IDLE));
    next_cycle();

    // Reset during a pending request; a later rvalid is ignored
    present(1'b1, 1'b0, F3_W, 32'h400, 32'h0);
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    check1("rst_req_pending", dmem_req, 1'b1);
    next_cycle();
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h33333333;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check1("rst_rvalid_nodone", Done, 1'b0);
    check32("rst_rvalid_state", 32'(dbg_state), 32'(S_IDLE));
    check32("rst_rvalid_rdata", ReadData, 32'h0);
    next_cycle();

    // Back-to-back access after reset still works
    do_access("post", 1'b1, 1'b0, F3_B, 32'h800, 32'h0, 0, 0, 32'h000000FE, 1'b0, 32'h800, 4'b0, 32'h0, 32'hFFFFFFFE);

    repeat (3) next_cycle();
    check32("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
